// File: rtl/solution_collector.sv
// solution_collector: gathers an 8-row one-hot placement, checks column and diagonal
// conflicts row by row, and counts accepted solutions.
module solution_collector (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       valid,
  input  logic [7:0] in_bus,
  input  logic       solver_done,
  input  logic [2:0] rd_row,
  output logic       busy,
  output logic       sol_valid,
  output logic       sol_ok,
  output logic [1:0] error_code,
  output logic [6:0] solution_count,
  output logic       finished,
  output logic [7:0] rd_data
);
  typedef enum logic [1:0] {IDLE, COLLECT, REPORT, FINISHED} state_t;
  state_t state_q, state_d;
  logic [7:0]  rows_q [8];
  logic [7:0]  rows_d [8];
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  col_q, col_d;
  logic [14:0] diag_q, diag_d, anti_q, anti_d;
  logic [1:0]  err_q, err_d, code;
  logic        ok_q, ok_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [7:0]  rev;
  logic [14:0] dbits, abits;
  logic        onehot, accept;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rows_q  <= '{default: '0};
      idx_q   <= 3'd7;
      col_q   <= '0;
      diag_q  <= '0;
      anti_q  <= '0;
      err_q   <= '0;
      ok_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      diag_q  <= diag_d;
      anti_q  <= anti_d;
      err_q   <= err_d;
      ok_q    <= ok_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start ? COLLECT : solver_done ? FINISHED : IDLE;
      COLLECT:  state_d = start ? COLLECT : solver_done ? FINISHED :
                          (valid && idx_q == 3'd0) ? REPORT : COLLECT;
      REPORT:   state_d = IDLE;
      FINISHED: state_d = start ? COLLECT : FINISHED;
      default:  state_d = IDLE;
    endcase
  end
  // Diagonal index r+c comes from shifting the row by r; anti-diagonal r-c+7 from shifting the bit-reversed row.
  always_comb begin
    rev = '0;
    for (int i = 0; i < 8; i++) rev[i] = in_bus[7-i];
    dbits  = {7'd0, in_bus} << idx_q;
    abits  = {7'd0, rev} << idx_q;
    onehot = (in_bus != 8'd0) && ((in_bus & (in_bus - 8'd1)) == 8'd0);
    code   = !onehot ? 2'b01 : (|(col_q & in_bus)) ? 2'b10 :
             (|(diag_q & dbits) || |(anti_q & abits)) ? 2'b11 : 2'b00;
    accept = state_q == COLLECT && !start && !solver_done && valid;
    rows_d = rows_q;
    idx_d  = idx_q;
    col_d  = col_q;
    diag_d = diag_q;
    anti_d = anti_q;
    err_d  = err_q;
    ok_d   = ok_q;
    cnt_d  = cnt_q;
    if (start && state_q != REPORT) begin
      idx_d  = 3'd7;
      col_d  = '0;
      diag_d = '0;
      anti_d = '0;
      err_d  = '0;
      ok_d   = 1'b0;
    end else if (accept) begin
      rows_d[idx_q] = in_bus;
      col_d  = onehot ? col_q | in_bus : col_q;
      diag_d = onehot ? diag_q | dbits : diag_q;
      anti_d = onehot ? anti_q | abits : anti_q;
      err_d  = (err_q == 2'b00) ? code : err_q;
      idx_d  = (idx_q == 3'd0) ? idx_q : idx_q - 3'd1;
      ok_d   = (idx_q == 3'd0) ? (err_d == 2'b00) : ok_q;
      cnt_d  = (idx_q == 3'd0 && ok_d && cnt_q != 7'd127) ? cnt_q + 7'd1 : cnt_q;
    end
  end
  always_comb begin
    busy           = state_q == COLLECT;
    sol_valid      = state_q == REPORT;
    finished       = state_q == FINISHED;
    sol_ok         = ok_q;
    error_code     = err_q;
    solution_count = cnt_q;
    rd_data        = rows_q[rd_row];
  end
endmodule

// File: tb/tb_solution_collector.sv
// tb_solution_collector: directed steps checking reset, solution checks, restarts, aborts and saturation.
module tb_solution_collector;
  logic       clk = 1'b0, reset = 1'b0, start = 1'b0, valid = 1'b0, solver_done = 1'b0;
  logic [7:0] in_bus = '0;
  logic [2:0] rd_row = '0;
  logic       busy, sol_valid, sol_ok, finished;
  logic [1:0] error_code;
  logic [6:0] solution_count;
  logic [7:0] rd_data;
  int errors = 0, checks = 0, exp_cnt = 0;
  localparam logic [63:0] SOL   = 64'h08_02_40_04_20_80_10_01;
  localparam logic [63:0] COLER = 64'h08_02_40_04_20_80_10_08;
  localparam logic [63:0] ZERO7 = 64'h00_02_40_04_20_80_10_01;
  localparam logic [63:0] ANTI6 = 64'h08_04_40_04_20_80_10_01;
  localparam logic [63:0] MULTI = 64'h03_02_40_04_20_80_10_01;

  solution_collector dut (
    .clk(clk), .reset(reset), .start(start), .valid(valid), .in_bus(in_bus),
    .solver_done(solver_done), .rd_row(rd_row), .busy(busy), .sol_valid(sol_valid),
    .sol_ok(sol_ok), .error_code(error_code), .solution_count(solution_count),
    .finished(finished), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_rows(input logic [63:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      chk("busy_row", {7'd0, busy}, 8'd1);
      valid  = 1'b1;
      in_bus = v[i*8 +: 8];
      step();
      valid  = 1'b0;
    end
  endtask

  task automatic report(input logic ok, input logic [1:0] ec);
    chk("sol_valid", {7'd0, sol_valid}, 8'd1);
    chk("sol_ok", {7'd0, sol_ok}, {7'd0, ok});
    chk("error_code", {6'd0, error_code}, {6'd0, ec});
    chk("count", {1'b0, solution_count}, 8'(exp_cnt));
    chk("busy_report", {7'd0, busy}, 8'd0);
    step();
    chk("sol_valid_drop", {7'd0, sol_valid}, 8'd0);
    chk("sol_ok_held", {7'd0, sol_ok}, {7'd0, ok});
  endtask

  task automatic xfer(input logic [63:0] v, input logic ok, input logic [1:0] ec);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("err_clr", {6'd0, error_code}, 8'd0);
    chk("ok_clr", {7'd0, sol_ok}, 8'd0);
    send_rows(v, 8);
    if (ok && exp_cnt < 127) exp_cnt++;
    report(ok, ec);
  endtask

  initial begin
    #3;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_sol_valid", {7'd0, sol_valid}, 8'd0);
    chk("rst_sol_ok", {7'd0, sol_ok}, 8'd0);
    chk("rst_err", {6'd0, error_code}, 8'd0);
    chk("rst_count", {1'b0, solution_count}, 8'd0);
    chk("rst_finished", {7'd0, finished}, 8'd0);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r);
      #1;
      chk("rst_rd_data", rd_data, 8'd0);
    end
    #10 reset = 1'b1;
    step();
    chk("idle_busy", {7'd0, busy}, 8'd0);
    xfer(SOL, 1'b1, 2'b00);
    rd_row = 3'd2;
    #1 chk("rd_row2", rd_data, 8'h80);
    rd_row = 3'd7;
    #1 chk("rd_row7", rd_data, 8'h08);
    xfer(COLER, 1'b0, 2'b10);
    rd_row = 3'd0;
    #1 chk("rd_err_row_written", rd_data, 8'h08);
    xfer(ZERO7, 1'b0, 2'b01);
    xfer(ANTI6, 1'b0, 2'b11);
    xfer(MULTI, 1'b0, 2'b01);
    // restart after 3 rows with a simultaneous valid that must be dropped
    start = 1'b1;
    step();
    start = 1'b0;
    send_rows(SOL, 3);
    start = 1'b1; valid = 1'b1; in_bus = 8'h01;
    step();
    start = 1'b0; valid = 1'b0;
    chk("restart_busy", {7'd0, busy}, 8'd1);
    send_rows(SOL, 8);
    exp_cnt++;
    report(1'b1, 2'b00);
    // abort via solver_done after 2 rows
    start = 1'b1;
    step();
    start = 1'b0;
    send_rows(SOL, 2);
    solver_done = 1'b1;
    step();
    solver_done = 1'b0;
    chk("abort_finished", {7'd0, finished}, 8'd1);
    chk("abort_sol_valid", {7'd0, sol_valid}, 8'd0);
    chk("abort_count", {1'b0, solution_count}, 8'(exp_cnt));
    step();
    chk("abort_no_sol_valid", {7'd0, sol_valid}, 8'd0);
    chk("finished_held", {7'd0, finished}, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("finished_clr", {7'd0, finished}, 8'd0);
    chk("finish_to_collect", {7'd0, busy}, 8'd1);
    for (int n = 0; n < 130; n++) xfer(SOL, 1'b1, 2'b00);
    chk("saturated", {1'b0, solution_count}, 8'd127);
    solver_done = 1'b1;
    step();
    solver_done = 1'b0;
    chk("idle_done_finished", {7'd0, finished}, 8'd1);
    // asynchronous reset in the middle of a transfer
    start = 1'b1;
    step();
    start = 1'b0;
    send_rows(COLER, 2);
    reset = 1'b0;
    rd_row = 3'd7;
    #1;
    chk("async_busy", {7'd0, busy}, 8'd0);
    chk("async_count", {1'b0, solution_count}, 8'd0);
    chk("async_rd", rd_data, 8'd0);
    #2 reset = 1'b1;
    step();
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    chk("post_rst_finished", {7'd0, finished}, 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/solution_collector.md
SOLUTION_COLLECTOR -- requirements
Module: solution_collector

Interface
REQ-001 The block SHALL use a single clock domain, and reset SHALL be asynchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port `reset`, input, 1 bit: asynchronous, active-low (0 = reset).
REQ-004 Port `start`, input, 1 bit: pulse marking the beginning of a new 8-row solution transfer.
REQ-005 Port `valid`, input, 1 bit: `in_bus` carries one row this cycle.
REQ-006 Port `in_bus`, input, 8 bits: one-hot column of the current row; bit c means column c.
REQ-007 Port `solver_done`, input, 1 bit: the solver has exhausted its search.
REQ-008 Port `rd_row`, input, 3 bits: row-register read address.
REQ-009 Port `busy`, output, 1 bit: high while in COLLECT.
REQ-010 Port `sol_valid`, output, 1 bit: one-cycle pulse when a solution check completes.
REQ-011 Port `sol_ok`, output, 1 bit: result of the last check; held until the next `start`.
REQ-012 Port `error_code`, output, 2 bits: 00 none, 01 not one-hot, 10 column clash, 11 diagonal clash.
REQ-013 Port `solution_count`, output, 7 bits: number of accepted valid solutions.
REQ-014 Port `finished`, output, 1 bit: the search has ended; held.
REQ-015 Port `rd_data`, output, 8 bits: combinational contents of row register `rd_row`.

Function
REQ-016 The block SHALL implement the states IDLE, COLLECT, REPORT and FINISHED as a Moore FSM.
REQ-017 Rows SHALL arrive in the order row 7 down to row 0, and an internal 3-bit row index SHALL load 7 on entry to COLLECT and decrement once per accepted `valid`.
REQ-018 In IDLE: `start` → COLLECT; otherwise `solver_done` → FINISHED; `valid` ignored.
REQ-019 On entering COLLECT, the block SHALL clear the column mask (8 bit), the diagonal mask (15 bit, index r+c) and the anti-diagonal mask (15 bit, index r-c+7), and SHALL clear `error_code` and `sol_ok`.
REQ-020 In COLLECT, each accepted `valid` SHALL write `in_bus` into row register [row index], whether or not the row is erroneous.
REQ-021 In COLLECT, each accepted `valid` SHALL set the corresponding mask bits.
REQ-022 In COLLECT, each accepted `valid` SHALL check the row, and the first error by arrival SHALL latch into `error_code`, with later errors ignored.
REQ-023 Within a single row, error priority SHALL be: not one-hot (zero bits or more than one bit set) > column clash > diagonal clash (either diagonal).
REQ-024 For a row that is not one-hot, the masks SHALL be left unchanged.
REQ-025 When `valid` is accepted with row index 0, the next edge SHALL enter REPORT.
REQ-026 On the edge that enters REPORT, `sol_ok` SHALL be set to (`error_code` == 00 including the row 0 check).
REQ-027 On the same edge, if `sol_ok` is set, `solution_count` SHALL increment, saturating at 127.
REQ-028 Latency SHALL be: the row 0 `valid` edge, then `sol_valid`, `sol_ok` and the new `solution_count` visible in the following cycle.
REQ-029 REPORT SHALL last exactly 1 cycle with `sol_valid`=1, then go to IDLE, and all inputs SHALL be ignored in REPORT.
REQ-030 In COLLECT, `start` SHALL restart COLLECT: partial data discarded, masks and row index reinitialised, `solution_count` unchanged, and a simultaneous `valid` dropped.
REQ-031 In COLLECT, `solver_done` without `start` SHALL abort to FINISHED with no `sol_valid` and `solution_count` unchanged.
REQ-032 FINISHED SHALL hold `finished`=1 until `start` (→ COLLECT, `finished` cleared) or reset.
REQ-033 `solution_count` SHALL be cleared only by reset.
REQ-034 `rd_data` SHALL be combinational from the row registers.

Reset
REQ-035 While `reset`=0, asynchronously: state IDLE, all row registers 00, masks 0, row index 7, `busy`=0, `sol_valid`=0, `sol_ok`=0, `error_code`=00, `solution_count`=0, `finished`=0.
REQ-036 Reset asserted mid-COLLECT SHALL discard the transfer, and the first edge after release SHALL be in IDLE.

Verification
REQ-037 Reset → all outputs 0, `rd_data`=00 for every `rd_row`.
REQ-038 `start`, then rows 7..0 = 08,02,40,04,20,80,10,01 → one cycle after row 0: `sol_valid`=1 for 1 cycle, `sol_ok`=1, `error_code`=00, `solution_count`=1; `rd_row`=2 → 80.
REQ-039 Same sequence with row 0 = 08 → `error_code`=10, `sol_ok`=0, `solution_count` unchanged.
REQ-040 Row 7 = 00, then rows 6..0 = 02,40,04,20,80,10,01 → `error_code`=01 (first error held), `sol_ok`=0.
REQ-041 `start`, 3 rows, `start`, then the full REQ-038 sequence → exactly one `sol_valid`, count +1; separately, `solver_done` after 2 rows → `finished`=1, no `sol_valid`.
REQ-042 130 valid solution transfers → `solution_count`=127; `solver_done` in IDLE → `finished`=1 next cycle.
